// File: rtl/stage0_flow_monitor_pkg.sv
// Shared constants for the stage0 flow monitor: redirect FSM encodings,
// parameter defaults and the error codes used when reporting.
package stage0_mon_pkg;

    localparam int XLEN_DEF     = 64;
    localparam int PC_STEP_DEF  = 4;
    localparam int MAX_WAIT_DEF = 16;
    localparam int CNT_W_DEF    = 32;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_PEND  = 2'd1;
    localparam fsm_state_t ST_CHECK = 2'd2;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_EPOCH    = 2'd1,
        ERR_REDIRECT = 2'd2,
        ERR_PC_SEQ   = 2'd3
    } err_code_e;

endpackage

// File: rtl/stage0_flow_monitor_if.sv
// Bundle of stage0 observation signals and monitor results.
// Every observed signal is sampled on the rising clock edge; there is no handshake, because the monitor never stalls.
interface stage0_flow_monitor_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    import stage0_mon_pkg::*;

    logic [XLEN-1:0]  rg_pc;
    logic             rg_pc_en;
    logic [XLEN-1:0]  rg_pc_d_in;
    logic             rg_eepoch;
    logic             rg_wepoch;
    logic             en_update_eepoch;
    logic             en_update_wepoch;
    logic             flush_valid;
    logic [XLEN-1:0]  flush_pc;
    logic             rg_delayed_redirect;
    logic             rg_fence;
    logic             rg_sfence;
    logic             pred_valid;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    logic             err_epoch;
    logic             err_redirect;
    logic             err_pc_seq;
    logic [XLEN-1:0]  first_err_pc;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] epoch_cnt;
    logic [CNT_W-1:0] fence_cnt;
    logic [CNT_W-1:0] fetch_cnt;
    fsm_state_t       fsm_state;

    modport master (
        output rg_pc, rg_pc_en, rg_pc_d_in, rg_eepoch, rg_wepoch,
               en_update_eepoch, en_update_wepoch, flush_valid, flush_pc,
               rg_delayed_redirect, rg_fence, rg_sfence,
               pred_valid, pred_taken, pred_target,
        input  err_epoch, err_redirect, err_pc_seq, first_err_pc,
               flush_cnt, epoch_cnt, fence_cnt, fetch_cnt, fsm_state
    );

    modport slave (
        input  rg_pc, rg_pc_en, rg_pc_d_in, rg_eepoch, rg_wepoch,
               en_update_eepoch, en_update_wepoch, flush_valid, flush_pc,
               rg_delayed_redirect, rg_fence, rg_sfence,
               pred_valid, pred_taken, pred_target,
        output err_epoch, err_redirect, err_pc_seq, first_err_pc,
               flush_cnt, epoch_cnt, fence_cnt, fetch_cnt, fsm_state
    );

endinterface

// File: rtl/stage0_flow_monitor_sat_counter.sv
// Event counter that adds 0, 1 or 2 per cycle and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (CNT_W + 1)'(inc);
        cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/stage0_flow_monitor.sv
// Passive monitor for fetch stage0: checks epoch toggles, redirect landing and next-PC sequencing.
// Also keeps saturating coverage counters. All results are registered.
module stage0_flow_monitor
    import stage0_mon_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int PC_STEP  = PC_STEP_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic            CLK,
    input logic            RST_N,
    stage0_flow_monitor_if.slave mon
);

    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    fsm_state_t      state_q, state_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            chk_en_q;
    logic            prev_eepoch_q, prev_wepoch_q;
    logic            prev_upd_e_q, prev_upd_w_q;
    logic            prev_fence_q, prev_sfence_q;
    logic            err_epoch_q, err_epoch_d;
    logic            err_redirect_q, err_redirect_d;
    logic            err_pc_seq_q, err_pc_seq_d;
    logic [XLEN-1:0] first_err_pc_q, first_err_pc_d;

    logic            redirect_bad, epoch_bad, seq_bad;
    logic [XLEN-1:0] seq_exp;
    logic [1:0]      flush_inc, epoch_inc, fence_inc, fetch_inc;

    // A new flush always wins: it re-targets the FSM and masks every other check.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        wait_d       = wait_q;
        redirect_bad = 1'b0;
        if (mon.flush_valid) begin
            tgt_d   = mon.flush_pc;
            wait_d  = '0;
            state_d = mon.rg_delayed_redirect ? ST_PEND : ST_CHECK;
        end else begin
            case (state_q)
                ST_PEND: begin
                    wait_d = wait_q + 1'b1;
                    if (!mon.rg_delayed_redirect) begin
                        state_d = ST_CHECK;
                    end else if (wait_d == WAIT_MAX) begin
                        redirect_bad = chk_en_q;
                        state_d      = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    redirect_bad = chk_en_q && (mon.rg_pc != tgt_q);
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        seq_exp   = (mon.pred_valid && mon.pred_taken) ? mon.pred_target
                                                       : mon.rg_pc + XLEN'(PC_STEP);
        epoch_bad = chk_en_q && !mon.flush_valid &&
                    ((mon.rg_eepoch != (prev_eepoch_q ^ prev_upd_e_q)) ||
                     (mon.rg_wepoch != (prev_wepoch_q ^ prev_upd_w_q)));
        seq_bad   = chk_en_q && mon.rg_pc_en && !mon.flush_valid &&
                    (state_q == ST_IDLE) && !mon.rg_fence && !mon.rg_sfence &&
                    (mon.rg_pc_d_in != seq_exp);

        err_epoch_d    = err_epoch_q    | epoch_bad;
        err_redirect_d = err_redirect_q | redirect_bad;
        err_pc_seq_d   = err_pc_seq_q   | seq_bad;
        first_err_pc_d = first_err_pc_q;
        if (!(err_epoch_q || err_redirect_q || err_pc_seq_q) &&
            (epoch_bad || redirect_bad || seq_bad))
            first_err_pc_d = mon.rg_pc;

        flush_inc = {1'b0, mon.flush_valid};
        epoch_inc = {1'b0, mon.en_update_eepoch} + {1'b0, mon.en_update_wepoch};
        fence_inc = {1'b0, mon.rg_fence && !prev_fence_q} +
                    {1'b0, mon.rg_sfence && !prev_sfence_q};
        fetch_inc = {1'b0, mon.rg_pc_en};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= ST_IDLE;
            tgt_q          <= '0;
            wait_q         <= '0;
            chk_en_q       <= 1'b0;
            prev_eepoch_q  <= 1'b0;
            prev_wepoch_q  <= 1'b0;
            prev_upd_e_q   <= 1'b0;
            prev_upd_w_q   <= 1'b0;
            prev_fence_q   <= 1'b0;
            prev_sfence_q  <= 1'b0;
            err_epoch_q    <= 1'b0;
            err_redirect_q <= 1'b0;
            err_pc_seq_q   <= 1'b0;
            first_err_pc_q <= '0;
        end else begin
            state_q        <= state_d;
            tgt_q          <= tgt_d;
            wait_q         <= wait_d;
            chk_en_q       <= 1'b1;
            prev_eepoch_q  <= mon.rg_eepoch;
            prev_wepoch_q  <= mon.rg_wepoch;
            prev_upd_e_q   <= mon.en_update_eepoch;
            prev_upd_w_q   <= mon.en_update_wepoch;
            prev_fence_q   <= mon.rg_fence;
            prev_sfence_q  <= mon.rg_sfence;
            err_epoch_q    <= err_epoch_d;
            err_redirect_q <= err_redirect_d;
            err_pc_seq_q   <= err_pc_seq_d;
            first_err_pc_q <= first_err_pc_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.CLK(CLK), .RST_N(RST_N), .inc(flush_inc), .cnt(mon.flush_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_epoch_cnt (.CLK(CLK), .RST_N(RST_N), .inc(epoch_inc), .cnt(mon.epoch_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_fence_cnt (.CLK(CLK), .RST_N(RST_N), .inc(fence_inc), .cnt(mon.fence_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (.CLK(CLK), .RST_N(RST_N), .inc(fetch_inc), .cnt(mon.fetch_cnt));

    assign mon.err_epoch    = err_epoch_q;
    assign mon.err_redirect = err_redirect_q;
    assign mon.err_pc_seq   = err_pc_seq_q;
    assign mon.first_err_pc = first_err_pc_q;
    assign mon.fsm_state    = state_q;

endmodule

// File: tb/tb_stage0_flow_monitor.sv
// Directed bench for stage0_flow_monitor; counters are narrowed to 4 bits so saturation is reachable.
module tb_stage0_flow_monitor;
    import stage0_mon_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   fails;

    stage0_flow_monitor_if #(.XLEN(64), .CNT_W(4)) mon_if ();

    stage0_flow_monitor #(.XLEN(64), .PC_STEP(4), .MAX_WAIT(16), .CNT_W(4)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .mon  (mon_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mon_if.rg_pc               = '0;
        mon_if.rg_pc_en            = 1'b0;
        mon_if.rg_pc_d_in          = '0;
        mon_if.rg_eepoch           = 1'b0;
        mon_if.rg_wepoch           = 1'b0;
        mon_if.en_update_eepoch    = 1'b0;
        mon_if.en_update_wepoch    = 1'b0;
        mon_if.flush_valid         = 1'b0;
        mon_if.flush_pc            = '0;
        mon_if.rg_delayed_redirect = 1'b0;
        mon_if.rg_fence            = 1'b0;
        mon_if.rg_sfence           = 1'b0;
        mon_if.pred_valid          = 1'b0;
        mon_if.pred_taken          = 1'b0;
        mon_if.pred_target         = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        mon_if.flush_valid         = 1'b1;
        mon_if.flush_pc            = 64'h0000_0000_8000_0100;
        mon_if.rg_delayed_redirect = 1'b1;
        cyc();
        mon_if.flush_valid = 1'b0;
        repeat (3) cyc();
        tests_run++;
        if (mon_if.fsm_state !== ST_PEND || mon_if.flush_cnt !== 4'd1) begin
            fails++;
            $display("FAIL rst_pre state=%0d flush_cnt=%0d exp state=1 flush_cnt=1", mon_if.fsm_state, mon_if.flush_cnt);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mon_if.fsm_state !== ST_IDLE || mon_if.flush_cnt !== 4'd0 || mon_if.err_redirect !== 1'b0 ||
            mon_if.err_epoch !== 1'b0 || mon_if.err_pc_seq !== 1'b0 || mon_if.first_err_pc !== 64'h0) begin
            fails++;
            $display("FAIL rst_async state=%0d flush_cnt=%0d errs=%b%b%b first=%h exp all zero",
                     mon_if.fsm_state, mon_if.flush_cnt, mon_if.err_epoch, mon_if.err_redirect,
                     mon_if.err_pc_seq, mon_if.first_err_pc);
        end
        clear_inputs();
        #2;
        rst_n = 1'b1;
        repeat (20) cyc();
        tests_run++;
        if (mon_if.err_redirect !== 1'b0 || mon_if.err_epoch !== 1'b0 || mon_if.err_pc_seq !== 1'b0 ||
            mon_if.fsm_state !== ST_IDLE) begin
            fails++;
            $display("FAIL rst_release errs=%b%b%b state=%0d exp 000 state=0",
                     mon_if.err_epoch, mon_if.err_redirect, mon_if.err_pc_seq, mon_if.fsm_state);
        end
    endtask

    task automatic test_flush_landing();
        do_reset();
        mon_if.flush_valid = 1'b1;
        mon_if.flush_pc    = 64'h0000_0000_8000_0200;
        cyc();
        tests_run++;
        if (mon_if.fsm_state !== ST_CHECK) begin
            fails++;
            $display("FAIL flush_to_check state=%0d exp 2", mon_if.fsm_state);
        end
        mon_if.flush_valid = 1'b0;
        mon_if.rg_pc       = 64'h0000_0000_8000_0200;
        cyc();
        tests_run++;
        if (mon_if.err_redirect !== 1'b0 || mon_if.flush_cnt !== 4'd1 || mon_if.fsm_state !== ST_IDLE) begin
            fails++;
            $display("FAIL flush_ok err_redirect=%b flush_cnt=%0d state=%0d exp 0 1 0",
                     mon_if.err_redirect, mon_if.flush_cnt, mon_if.fsm_state);
        end

        do_reset();
        mon_if.flush_valid = 1'b1;
        mon_if.flush_pc    = 64'h0000_0000_8000_0200;
        cyc();
        mon_if.flush_valid = 1'b0;
        mon_if.rg_pc       = 64'h0000_0000_8000_0204;
        cyc();
        tests_run++;
        if (mon_if.err_redirect !== 1'b1 || mon_if.first_err_pc !== 64'h0000_0000_8000_0204 ||
            mon_if.err_epoch !== 1'b0 || mon_if.err_pc_seq !== 1'b0) begin
            fails++;
            $display("FAIL flush_bad err_redirect=%b first=%h e=%b s=%b exp 1 0000000080000204 0 0",
                     mon_if.err_redirect, mon_if.first_err_pc, mon_if.err_epoch, mon_if.err_pc_seq);
        end
    endtask

    task automatic test_delayed_redirect();
        do_reset();
        mon_if.flush_valid         = 1'b1;
        mon_if.flush_pc            = 64'h0000_0000_8000_0100;
        mon_if.rg_delayed_redirect = 1'b1;
        mon_if.rg_pc               = 64'h0000_0000_0000_1234;
        cyc();
        mon_if.flush_valid = 1'b0;
        repeat (15) cyc();
        tests_run++;
        if (mon_if.err_redirect !== 1'b0 || mon_if.fsm_state !== ST_PEND) begin
            fails++;
            $display("FAIL pend_15 err_redirect=%b state=%0d exp 0 1", mon_if.err_redirect, mon_if.fsm_state);
        end
        cyc();
        tests_run++;
        if (mon_if.err_redirect !== 1'b1 || mon_if.fsm_state !== ST_IDLE ||
            mon_if.first_err_pc !== 64'h0000_0000_0000_1234) begin
            fails++;
            $display("FAIL pend_timeout err_redirect=%b state=%0d first=%h exp 1 0 0000000000001234",
                     mon_if.err_redirect, mon_if.fsm_state, mon_if.first_err_pc);
        end

        do_reset();
        mon_if.flush_valid         = 1'b1;
        mon_if.flush_pc            = 64'h0000_0000_8000_0300;
        mon_if.rg_delayed_redirect = 1'b1;
        cyc();
        mon_if.flush_valid = 1'b0;
        repeat (5) cyc();
        mon_if.rg_delayed_redirect = 1'b0;
        cyc();
        tests_run++;
        if (mon_if.fsm_state !== ST_CHECK) begin
            fails++;
            $display("FAIL pend_release state=%0d exp 2", mon_if.fsm_state);
        end
        mon_if.rg_pc = 64'h0000_0000_8000_0300;
        cyc();
        tests_run++;
        if (mon_if.err_redirect !== 1'b0 || mon_if.fsm_state !== ST_IDLE) begin
            fails++;
            $display("FAIL pend_land err_redirect=%b state=%0d exp 0 0", mon_if.err_redirect, mon_if.fsm_state);
        end
    endtask

    task automatic test_seq_pc();
        do_reset();
        mon_if.rg_pc_en   = 1'b1;
        mon_if.rg_pc      = 64'hFFFF_FFFF_FFFF_FFFC;
        mon_if.rg_pc_d_in = 64'h0;
        cyc();
        tests_run++;
        if (mon_if.err_pc_seq !== 1'b0 || mon_if.fetch_cnt !== 4'd1) begin
            fails++;
            $display("FAIL seq_wrap err_pc_seq=%b fetch_cnt=%0d exp 0 1", mon_if.err_pc_seq, mon_if.fetch_cnt);
        end
        mon_if.rg_pc       = 64'h0000_0000_8000_0000;
        mon_if.pred_valid  = 1'b1;
        mon_if.pred_taken  = 1'b1;
        mon_if.pred_target = 64'h0000_0000_8000_1000;
        mon_if.rg_pc_d_in  = 64'h0000_0000_8000_1000;
        cyc();
        tests_run++;
        if (mon_if.err_pc_seq !== 1'b0) begin
            fails++;
            $display("FAIL seq_pred err_pc_seq=%b exp 0", mon_if.err_pc_seq);
        end
        mon_if.pred_valid = 1'b0;
        mon_if.pred_taken = 1'b0;
        mon_if.rg_fence   = 1'b1;
        mon_if.rg_pc      = 64'h100;
        mon_if.rg_pc_d_in = 64'h999;
        cyc();
        tests_run++;
        if (mon_if.err_pc_seq !== 1'b0 || mon_if.fence_cnt !== 4'd1) begin
            fails++;
            $display("FAIL seq_fence err_pc_seq=%b fence_cnt=%0d exp 0 1", mon_if.err_pc_seq, mon_if.fence_cnt);
        end
        mon_if.rg_fence    = 1'b0;
        mon_if.flush_valid = 1'b1;
        mon_if.flush_pc    = 64'h200;
        cyc();
        tests_run++;
        if (mon_if.err_pc_seq !== 1'b0 || mon_if.fsm_state !== ST_CHECK) begin
            fails++;
            $display("FAIL seq_flush_prio err_pc_seq=%b state=%0d exp 0 2", mon_if.err_pc_seq, mon_if.fsm_state);
        end
        mon_if.flush_valid = 1'b0;
        mon_if.rg_pc_en    = 1'b0;
        mon_if.rg_pc       = 64'h200;
        cyc();
        tests_run++;
        if (mon_if.err_redirect !== 1'b0 || mon_if.fetch_cnt !== 4'd4) begin
            fails++;
            $display("FAIL seq_after_flush err_redirect=%b fetch_cnt=%0d exp 0 4", mon_if.err_redirect, mon_if.fetch_cnt);
        end
        mon_if.rg_pc_en   = 1'b1;
        mon_if.rg_pc      = 64'hFFFF_FFFF_FFFF_FFFC;
        mon_if.rg_pc_d_in = 64'h8;
        cyc();
        tests_run++;
        if (mon_if.err_pc_seq !== 1'b1 || mon_if.first_err_pc !== 64'hFFFF_FFFF_FFFF_FFFC ||
            mon_if.fetch_cnt !== 4'd5 || mon_if.err_redirect !== 1'b0) begin
            fails++;
            $display("FAIL seq_bad err_pc_seq=%b first=%h fetch_cnt=%0d r=%b exp 1 fffffffffffffffc 5 0",
                     mon_if.err_pc_seq, mon_if.first_err_pc, mon_if.fetch_cnt, mon_if.err_redirect);
        end
    endtask

    task automatic test_epoch();
        do_reset();
        mon_if.en_update_eepoch = 1'b1;
        mon_if.en_update_wepoch = 1'b1;
        cyc();
        mon_if.en_update_eepoch = 1'b0;
        mon_if.en_update_wepoch = 1'b0;
        mon_if.rg_eepoch        = 1'b1;
        mon_if.rg_wepoch        = 1'b1;
        cyc();
        tests_run++;
        if (mon_if.epoch_cnt !== 4'd2 || mon_if.err_epoch !== 1'b0) begin
            fails++;
            $display("FAIL epoch_both epoch_cnt=%0d err_epoch=%b exp 2 0", mon_if.epoch_cnt, mon_if.err_epoch);
        end
        mon_if.en_update_eepoch = 1'b1;
        cyc();
        mon_if.en_update_eepoch = 1'b0;
        mon_if.rg_pc            = 64'h40;
        cyc();
        tests_run++;
        if (mon_if.err_epoch !== 1'b1 || mon_if.epoch_cnt !== 4'd3 || mon_if.first_err_pc !== 64'h40 ||
            mon_if.err_pc_seq !== 1'b0) begin
            fails++;
            $display("FAIL epoch_missing err_epoch=%b epoch_cnt=%0d first=%h s=%b exp 1 3 0000000000000040 0",
                     mon_if.err_epoch, mon_if.epoch_cnt, mon_if.first_err_pc, mon_if.err_pc_seq);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_cnt [4];
        exp_cnt[0] = 4'd13;
        exp_cnt[1] = 4'd14;
        exp_cnt[2] = 4'd15;
        exp_cnt[3] = 4'd15;
        do_reset();
        mon_if.flush_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            mon_if.flush_pc = 64'h0000_0000_8000_0000 + 64'(i * 16);
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (mon_if.flush_cnt !== exp_cnt[k]) begin
                fails++;
                $display("FAIL flush_sat_%0d flush_cnt=%0d exp %0d", k, mon_if.flush_cnt, exp_cnt[k]);
            end
            if (k < 3) begin
                mon_if.flush_pc = 64'h0000_0000_9000_0000 + 64'(k * 16);
                cyc();
            end
        end
        mon_if.flush_valid = 1'b0;
        mon_if.rg_pc       = 64'h0000_0000_9000_0020;
        cyc();
        tests_run++;
        if (mon_if.err_redirect !== 1'b0 || mon_if.fsm_state !== ST_IDLE || mon_if.flush_cnt !== 4'd15) begin
            fails++;
            $display("FAIL b2b_land err_redirect=%b state=%0d flush_cnt=%0d exp 0 0 15",
                     mon_if.err_redirect, mon_if.fsm_state, mon_if.flush_cnt);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        rst_n     = 1'b0;
        clear_inputs();
        test_reset();
        test_flush_landing();
        test_delayed_redirect();
        test_seq_pc();
        test_epoch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/stage0_flow_monitor.md
Name: stage0_flow_monitor

Overview:
Synthesizable protocol monitor for the fetch PC-generation stage (stage0) of the chromite core, bound alongside the SoC in the simulation top. It consumes stage0 PC/epoch/flush/redirect state each cycle. It checks epoch-toggle, redirect-landing and sequential-PC rules, and keeps saturating event counters for coverage. It has no effect on the DUT; it only drives its own outputs into the bench interface.

Parameters:
XLEN, 64, PC width
PC_STEP, 4, expected PC increment when no redirect or prediction is taken
MAX_WAIT, 16, max cycles a delayed redirect may stay pending
CNT_W, 32, width of each event counter

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
rg_pc  in  XLEN  current stage0 PC register
rg_pc_en  in  1  PC register write enable this cycle
rg_pc_d_in  in  XLEN  PC register next value
rg_eepoch  in  1  execute epoch bit
rg_wepoch  in  1  writeback epoch bit
en_update_eepoch  in  1  eEpoch toggle request
en_update_wepoch  in  1  wEpoch toggle request
flush_valid  in  1  ma_flush_fl valid
flush_pc  in  XLEN  flush target
rg_delayed_redirect  in  1  redirect deferred by stage0
rg_fence  in  1  fence pending
rg_sfence  in  1  sfence pending
pred_valid  in  1  BPU prediction response valid
pred_taken  in  1  prediction taken
pred_target  in  XLEN  predicted target
err_epoch  out  1  sticky: epoch rule violated
err_redirect  out  1  sticky: flush target mismatch or timeout
err_pc_seq  out  1  sticky: sequential/predicted next-PC mismatch
first_err_pc  out  XLEN  rg_pc at the first error of any kind
flush_cnt  out  CNT_W  flushes seen
epoch_cnt  out  CNT_W  epoch toggles (e plus w)
fence_cnt  out  CNT_W  rising edges of rg_fence or rg_sfence
fetch_cnt  out  CNT_W  cycles with rg_pc_en=1

Behaviour:
- Reset (RST_N=0, async): all errors 0, first_err_pc 0, counters 0, FSM IDLE, sample registers 0. Checks are disabled during reset and in the first cycle after reset release (prev-sample registers invalid).
- Epoch check: register previous eepoch/wepoch and update requests. Each cycle, rg_eepoch must equal prev_eepoch ^ prev_en_update_eepoch; the same rule applies to wepoch. A mismatch sets err_epoch. Each toggle request adds 1 to epoch_cnt; two requests in one cycle add 2.
- Redirect FSM, states IDLE / PEND / CHECK:
  - IDLE + flush_valid: latch flush_pc into tgt. Go to PEND if rg_delayed_redirect=1, else CHECK. flush_cnt+1.
  - PEND: wait_cnt increments each cycle. If rg_delayed_redirect=0, go to CHECK. If wait_cnt reaches MAX_WAIT, set err_redirect and go to IDLE.
  - CHECK (one cycle): rg_pc must equal tgt, otherwise set err_redirect. Then go to IDLE.
  - A new flush_valid in PEND or CHECK: re-latch tgt, clear wait_cnt, flush_cnt+1, re-evaluate the PEND/CHECK choice. No check is made against the old target.
- Sequential PC check applies only when rg_pc_en=1, flush_valid=0 and FSM=IDLE:
  - If pred_valid and pred_taken: rg_pc_d_in must equal pred_target.
  - Otherwise: rg_pc_d_in must equal rg_pc+PC_STEP, mod 2^XLEN (wrap is legal).
  - A mismatch sets err_pc_seq.
  - Skipped while rg_fence or rg_sfence is 1 (fence restart is checked via the flush path).
- Flush has priority over every other check in the same cycle.
- first_err_pc is written only when no error flag was previously set. Simultaneous first errors record one rg_pc, with all of the corresponding flags set.
- Counters saturate at all-ones.
- Combinational outputs: none. Every output is registered, so flags and counters appear one cycle after the triggering sample.

Decomposition:
- Shared package stage0_mon_pkg: FSM enum (IDLE, PEND, CHECK), XLEN/PC_STEP defaults, and an error-code enum for bench reporting.
- One sub-module, sat_counter (CNT_W, increment 0..2, saturating), instantiated four times.

Test Plan:
- Reset mid-PEND (flush at 0x8000_0100 with delayed redirect, RST_N low after 3 cycles) -> FSM IDLE, all outputs 0 immediately, no error after release.
- Flush 0x8000_0200, delayed_redirect=0, rg_pc=0x8000_0200 next cycle -> no error, flush_cnt=1. Repeat with rg_pc=0x8000_0204 -> err_redirect=1, first_err_pc=0x8000_0204.
- Delayed redirect held for 16 cycles -> err_redirect asserted on the 16th pending cycle. Held for 5 cycles, then landing on target -> no error.
- Sequential fetch with rg_pc=0xFFFF_FFFF_FFFF_FFFC and d_in=0 -> no error (wrap). d_in=0x8 -> err_pc_seq. Predicted-taken to 0x8000_1000 with d_in=0x8000_1000 -> no error.
- en_update_eepoch and en_update_wepoch in the same cycle, both epochs toggled next cycle -> epoch_cnt+=2, no error. Request with no toggle -> err_epoch=1.
- flush_cnt preloaded near all-ones, then three flushes -> counter holds at 2^CNT_W-1.
